vec_sequencer: RTL



---
 rtl/vec_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vec_sequencer.sv
// Load/drain sequencer for the 4-lane vector datapath: forwards operand words and drives stage enables.
// Optional VEC_SEQ_STALL_CNT_EN adds a saturating stall_cnt output counting mid-vector input stalls.
module vec_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [7:0]  dp_din,
    output logic        en_a1,
    output logic        en_a2,
    output logic        en_a3,
    output logic        en_a4,
    output logic        en_b1,
    output logic        en_b2,
    output logic        en_b3,
    output logic        en_b4,
    output logic        en_add1_1,
    output logic        en_add1_2,
    output logic        en_add1_3,
    output logic        en_add1_4,
    output logic        en_add2_1,
    output logic        en_add2_2,
    output logic        en_add2_3,
    output logic        en_add2_4,
    output logic        en_f1,
    output logic        en_f2,
    output logic        en_f3,
    output logic        en_f4,
    output logic        save_c,
    output logic        busy
`ifdef VEC_SEQ_STALL_CNT_EN
    ,
    output logic [15:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {LOAD, DRAIN1, DRAIN2, RESULT} state_t;

    state_t     state, state_next;
    logic [3:0] beat, beat_next;
    logic [3:0] ea, eb, eadd1, eadd2, ef;
    logic       sc, rv, fire;

    assign in_ready = (state == LOAD) && !rst;
    assign fire     = in_valid && in_ready;
    assign dp_din   = in_data;
    assign busy     = !((state == LOAD) && (beat == 4'd0));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            beat  <= 4'd0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
        end
    end

    always_comb begin
        state_next = state;
        beat_next  = beat;
        ea         = 4'b0;
        eb         = 4'b0;
        eadd1      = 4'b0;
        eadd2      = 4'b0;
        ef         = 4'b0;
        sc         = 1'b0;
        rv         = 1'b0;
        case (state)
            LOAD: begin
                if (fire) begin
                    case (beat)
                        4'd0:    ea[0] = 1'b1;
                        4'd1:    ea[1] = 1'b1;
                        4'd2:    ea[2] = 1'b1;
                        4'd3:    ea[3] = 1'b1;
                        4'd4:    eb[0] = 1'b1;
                        4'd5:    begin eb[1] = 1'b1; ea[0] = 1'b1; sc = 1'b1; end
                        4'd6:    begin eb[2] = 1'b1; ea[1] = 1'b1; sc = 1'b1; end
                        4'd7:    begin eb[3] = 1'b1; ea[2] = 1'b1; sc = 1'b1; end
                        4'd8:    begin ea[3] = 1'b1; eadd1[0] = 1'b1; sc = 1'b1; end
                        4'd9:    begin eadd1[1] = 1'b1; eadd2[0] = 1'b1; end
                        4'd10:   begin eadd1[2] = 1'b1; eadd2[1] = 1'b1; ef[0] = 1'b1; end
                        4'd11:   begin eadd1[3] = 1'b1; eadd2[2] = 1'b1; ef[1] = 1'b1; end
                        default: ;
                    endcase
                    if (beat == 4'd11) begin
                        beat_next  = 4'd0;
                        state_next = DRAIN1;
                    end else begin
                        beat_next = beat + 4'd1;
                    end
                end
            end
            DRAIN1: begin
                eadd2[3]   = 1'b1;
                ef[2]      = 1'b1;
                state_next = DRAIN2;
            end
            DRAIN2: begin
                ef[3]      = 1'b1;
                state_next = RESULT;
            end
            RESULT: begin
                rv = 1'b1;
                if (res_ready) begin
                    state_next = LOAD;
                    beat_next  = 4'd0;
                end
            end
            default: state_next = LOAD;
        endcase
        // nothing may reach the datapath during the reset cycle
        if (rst) begin
            ea    = 4'b0;
            eb    = 4'b0;
            eadd1 = 4'b0;
            eadd2 = 4'b0;
            ef    = 4'b0;
            sc    = 1'b0;
            rv    = 1'b0;
        end
    end

    assign {en_a4, en_a3, en_a2, en_a1}             = ea;
    assign {en_b4, en_b3, en_b2, en_b1}             = eb;
    assign {en_add1_4, en_add1_3, en_add1_2, en_add1_1} = eadd1;
    assign {en_add2_4, en_add2_3, en_add2_2, en_add2_1} = eadd2;
    assign {en_f4, en_f3, en_f2, en_f1}             = ef;
    assign save_c    = sc;
    assign res_valid = rv;

`ifdef VEC_SEQ_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= 16'd0;
        else if (fire && (beat == 4'd0))
            stall_cnt <= 16'd0;
        else if ((state == LOAD) && !in_valid && (beat != 4'd0) && (stall_cnt != 16'hFFFF))
            stall_cnt <= stall_cnt + 16'd1;
    end
`endif

endmodule
